// File: rtl/param_access_sequencer.sv
// param_access_sequencer
//
// Sequences one read or write access to a parameter bank per start edge from
// a control PIO. The command is captured on the start edge, range-checked
// against the bank address width, issued as a registered request, and closed
// by either an acknowledge or a timeout. Status is reported through sticky
// flags and a completed-transaction counter.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   cmd_addr         target address (upper bits must be zero to be in range)
//   cmd_wdata        write data
//   cmd_ctrl         [0] start (rising edge), [1] 1=read 0=write, [2] clear status (level)
//   param_addr       bank address, held for the whole request
//   param_wdata      bank write data, held for the whole request
//   param_wr/rd      registered request strobes, at most one high
//   param_rdata      bank read data, valid with param_ack
//   param_ack        bank acknowledge, only honoured while requesting
//   stat_busy        transaction in progress
//   stat_done        sticky completion flag
//   stat_err         00 ok, 01 timeout, 10 address out of range
//   stat_overrun     sticky: start edge seen while a transaction was active
//   rdata_out        last successful read result
//   xfer_count       completed transactions (errors included), wraps at 16 bits
//
// Handshake: a request is open while param_wr or param_rd is high. The bank
// answers by driving param_ack high for the cycle it wants sampled; the
// request drops on the edge that samples it. Ack at any other time is ignored.

module param_access_sequencer #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [2:0]        cmd_ctrl,
  output logic [ADDR_W-1:0] param_addr,
  output logic [31:0]       param_wdata,
  output logic              param_wr,
  output logic              param_rd,
  input  logic [31:0]       param_rdata,
  input  logic              param_ack,
  output logic              stat_busy,
  output logic              stat_done,
  output logic [1:0]        stat_err,
  output logic              stat_overrun,
  output logic [31:0]       rdata_out,
  output logic [15:0]       xfer_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_REQ   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0]  ERR_OK      = 2'b00;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b01;
  localparam logic [1:0]  ERR_RANGE   = 2'b10;
  // Timer counts completed request cycles; the request cycle that sees this
  // value is the last one allowed.
  localparam logic [15:0] TIMER_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;

  logic        start_prev_q, start_prev_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        dir_rd_q, dir_rd_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic        overrun_q, overrun_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] count_q, count_d;
  logic [15:0] timer_q, timer_d;

  logic start_edge;
  logic clear_req;
  logic addr_out_of_range;
  logic timer_expired;

  assign start_edge        = cmd_ctrl[0] & ~start_prev_q;
  assign clear_req         = cmd_ctrl[2];
  // Any captured address bit at or above ADDR_W puts the target outside the bank.
  assign addr_out_of_range = (addr_q >> ADDR_W) != 32'd0;
  assign timer_expired     = (timer_q == TIMER_LAST);

  // State register (all flops share the asynchronous reset)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      dir_rd_q     <= 1'b0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= ERR_OK;
      overrun_q    <= 1'b0;
      rdata_q      <= '0;
      count_q      <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      dir_rd_q     <= dir_rd_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      overrun_q    <= overrun_d;
      rdata_q      <= rdata_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_edge) state_d = S_CHECK;
      S_CHECK: state_d = addr_out_of_range ? S_DONE : S_REQ;
      // Ack is tested first so that it wins over the final timeout cycle.
      S_REQ:   if (param_ack || timer_expired) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    start_prev_d = cmd_ctrl[0];
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    dir_rd_d     = dir_rd_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    overrun_d    = overrun_q;
    rdata_d      = rdata_q;
    count_d      = count_q;
    timer_d      = timer_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          addr_d   = cmd_addr;
          wdata_d  = cmd_wdata;
          dir_rd_d = cmd_ctrl[1];
          done_d   = 1'b0;
          err_d    = ERR_OK;
          busy_d   = 1'b1;
        end
      end
      S_CHECK: begin
        if (addr_out_of_range) begin
          err_d = ERR_RANGE;
        end else begin
          timer_d = '0;
          // Strobes are raised here so they are already registered on the
          // first REQ cycle.
          wr_d    = ~dir_rd_q;
          rd_d    = dir_rd_q;
        end
      end
      S_REQ: begin
        timer_d = timer_q + 16'd1;
        if (param_ack) begin
          wr_d  = 1'b0;
          rd_d  = 1'b0;
          err_d = ERR_OK;
          if (dir_rd_q) rdata_d = param_rdata;
        end else if (timer_expired) begin
          wr_d  = 1'b0;
          rd_d  = 1'b0;
          err_d = ERR_TIMEOUT;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        count_d = count_q + 16'd1;
      end
      default: begin
        wr_d = 1'b0;
        rd_d = 1'b0;
      end
    endcase

    // A start edge while a transaction is in flight is dropped but recorded.
    if (start_edge && (state_q != S_IDLE)) overrun_d = 1'b1;

    // Clear is a level and overrides every status update in the same cycle;
    // it never touches the transaction itself.
    if (clear_req) begin
      done_d    = 1'b0;
      err_d     = ERR_OK;
      overrun_d = 1'b0;
    end
  end

  assign param_addr   = addr_q[ADDR_W-1:0];
  assign param_wdata  = wdata_q;
  assign param_wr     = wr_q;
  assign param_rd     = rd_q;
  assign stat_busy    = busy_q;
  assign stat_done    = done_q;
  assign stat_err     = err_q;
  assign stat_overrun = overrun_q;
  assign rdata_out    = rdata_q;
  assign xfer_count   = count_q;

endmodule
